// File: rtl/rgb8_sample_accum_pkg.sv
// Shared types for the RGB8 multi-sample accumulator.
// Channel index 0 is red, 1 green, 2 blue.
package rgb8_sample_accum_pkg;

    localparam int NCH = 3;
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int MAX_SAMPLES_DEF = 255;

    typedef logic [NCH-1:0][7:0] rgb8_t;
    typedef logic [NCH-1:0][15:0] rgb16_t;

    typedef enum logic [1:0] {
        ACCUM,
        DIV_REQ,
        DIV_WAIT,
        OUTPUT
    } accum_state_t;

endpackage

// File: rtl/rgb8_sample_accum.sv
// Per-pixel RGB8 sample accumulator feeding an external per-channel divider.
// Single-sample pixels bypass the divider entirely.
module rgb8_sample_accum
    import rgb8_sample_accum_pkg::*;
#(
    parameter int MAX_SAMPLES = MAX_SAMPLES_DEF,
    parameter int ADDR_W      = 19,
    parameter int ROUND       = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  rgb8_t             in_color,
    input  logic              in_last,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              div_strobe,
    output rgb16_t            div_a,
    output logic [7:0]        div_b,
    input  logic              div_valid,
    input  rgb8_t             div_q,
    output logic              out_valid,
    input  logic              out_ready,
    output rgb8_t             out_color,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_count
);

    localparam logic [7:0] MAX_COUNT = MAX_SAMPLES[7:0];

    accum_state_t state;
    accum_state_t state_nxt;

    rgb16_t     sum;
    rgb16_t     sum_nxt;
    rgb16_t     dividend;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic [7:0] bias;
    logic       accept;
    logic       complete;
    logic       bypass;

    assign accept    = in_valid & in_ready;
    assign count_nxt = count + 8'd1;
    assign complete  = accept & (in_last | (count_nxt == MAX_COUNT));
    assign bypass    = (count_nxt == 8'd1);
    assign bias      = (ROUND != 0) ? (count_nxt >> 1) : 8'd0;

    // 255*255 + 127 still fits in 16 bits, so no saturation is needed.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign sum_nxt[c]  = sum[c] + {8'd0, in_color[c]};
        assign dividend[c] = sum_nxt[c] + {8'd0, bias};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        div_strobe = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (complete) begin
                    state_nxt = bypass ? OUTPUT : DIV_REQ;
                end
            end
            DIV_REQ: begin
                div_strobe = 1'b1;
                state_nxt  = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_valid) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum       <= '0;
            count     <= '0;
            div_a     <= '0;
            div_b     <= '0;
            out_color <= '0;
            out_addr  <= '0;
            out_count <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        sum   <= sum_nxt;
                        count <= count_nxt;
                        if (count == 8'd0) begin
                            out_addr <= in_addr;
                        end
                        if (complete) begin
                            out_count <= count_nxt;
                            if (bypass) begin
                                out_color <= in_color;
                            end else begin
                                div_a <= dividend;
                                div_b <= count_nxt;
                            end
                        end
                    end
                end
                DIV_WAIT: begin
                    if (div_valid) begin
                        out_color <= div_q;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        sum   <= '0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb8_sample_accum.sv
// Bench for rgb8_sample_accum: a rounding and a truncating instance share
// stimulus; a small behavioural divider answers their divide requests.
module tb_rgb8_sample_accum;
    import rgb8_sample_accum_pkg::*;

    localparam int AW  = 19;
    localparam int LAT = 3;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_last;
    rgb8_t         in_color;
    logic [AW-1:0] in_addr;
    logic          out_ready;
    logic          div_valid;
    rgb8_t         div_q0;
    rgb8_t         div_q1;

    logic          in_ready0, in_ready1;
    logic          div_strobe0, div_strobe1;
    rgb16_t        div_a0, div_a1;
    logic [7:0]    div_b0, div_b1;
    logic          out_valid0, out_valid1;
    rgb8_t         out_color0, out_color1;
    logic [AW-1:0] out_addr0, out_addr1;
    logic [7:0]    out_count0, out_count1;

    rgb8_sample_accum #(.MAX_SAMPLES(255), .ADDR_W(AW), .ROUND(1)) dut0 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready0), .in_color(in_color),
        .in_last(in_last), .in_addr(in_addr),
        .div_strobe(div_strobe0), .div_a(div_a0), .div_b(div_b0),
        .div_valid(div_valid), .div_q(div_q0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_color(out_color0),
        .out_addr(out_addr0), .out_count(out_count0)
    );

    rgb8_sample_accum #(.MAX_SAMPLES(255), .ADDR_W(AW), .ROUND(0)) dut1 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready1), .in_color(in_color),
        .in_last(in_last), .in_addr(in_addr),
        .div_strobe(div_strobe1), .div_a(div_a1), .div_b(div_b1),
        .div_valid(div_valid), .div_q(div_q1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_color(out_color1),
        .out_addr(out_addr1), .out_count(out_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          sel;
    logic          o_ready, o_strobe, o_valid;
    rgb16_t        o_a;
    logic [7:0]    o_b, o_count;
    rgb8_t         o_color;
    logic [AW-1:0] o_addr;

    assign o_ready  = sel ? in_ready1   : in_ready0;
    assign o_strobe = sel ? div_strobe1 : div_strobe0;
    assign o_a      = sel ? div_a1      : div_a0;
    assign o_b      = sel ? div_b1      : div_b0;
    assign o_valid  = sel ? out_valid1  : out_valid0;
    assign o_color  = sel ? out_color1  : out_color0;
    assign o_addr   = sel ? out_addr1   : out_addr0;
    assign o_count  = sel ? out_count1  : out_count0;

    // Behavioural divider; the stray flag injects an unsolicited result.
    logic  div_en;
    logic  mdl_valid;
    logic  stray;
    rgb8_t mq0, mq1;

    assign div_valid = mdl_valid | stray;
    assign div_q0    = stray ? {3{8'd77}} : mq0;
    assign div_q1    = stray ? {3{8'd77}} : mq1;

    initial begin
        rgb16_t     a0, a1;
        logic [7:0] b0, b1;
        logic [15:0] t;
        mdl_valid = 1'b0;
        mq0 = '0;
        mq1 = '0;
        forever begin
            @(negedge clk);
            if (div_en && resetn && div_strobe0) begin
                a0 = div_a0; b0 = div_b0;
                a1 = div_a1; b1 = div_b1;
                repeat (LAT) @(negedge clk);
                for (int ch = 0; ch < NCH; ch++) begin
                    t = a0[ch] / {8'd0, b0};
                    mq0[ch] = t[7:0];
                    t = a1[ch] / {8'd0, b1};
                    mq1[ch] = t[7:0];
                end
                mdl_valid = 1'b1;
                @(negedge clk);
                mdl_valid = 1'b0;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rgb8_t rgb(input int r, input int g, input int b);
        rgb8_t x;
        x[CH_R] = 8'(r);
        x[CH_G] = 8'(g);
        x[CH_B] = 8'(b);
        return x;
    endfunction

    function automatic rgb16_t rgb16(input int r, input int g, input int b);
        rgb16_t x;
        x[CH_R] = 16'(r);
        x[CH_G] = 16'(g);
        x[CH_B] = 16'(b);
        return x;
    endfunction

    typedef struct {
        int                   n;
        logic [2:0][2:0][7:0] c;
        logic [AW-1:0]        addr;
        logic                 trunc;
        logic                 strobe;
        rgb16_t               a;
        logic [7:0]           b;
        rgb8_t                q;
    } pix_t;

    pix_t tbl [7];

    task automatic run_pixel(input string tag, input pix_t v, input int hold);
        int cyc;
        int extra;
        sel = v.trunc;
        for (int s = 0; s < v.n; s++) begin
            in_valid = 1'b1;
            in_color = v.c[s];
            in_last  = (s == v.n - 1);
            in_addr  = (s == 0) ? v.addr : ~v.addr;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_strobe"}, o_strobe, v.strobe);
        chk({tag, "_in_ready_busy"}, o_ready, 1'b0);
        if (v.strobe) begin
            chk({tag, "_div_a"}, o_a, v.a);
            chk({tag, "_div_b"}, o_b, v.b);
        end else begin
            chk({tag, "_bypass_valid"}, o_valid, 1'b1);
        end
        cyc = 0;
        extra = 0;
        while (!o_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (o_strobe) extra++;
        end
        if (v.strobe) chk({tag, "_strobe_once"}, 64'(extra), 64'd0);
        chk({tag, "_out_valid"}, o_valid, 1'b1);
        chk({tag, "_out_color"}, o_color, v.q);
        chk({tag, "_out_addr"}, o_addr, v.addr);
        chk({tag, "_out_count"}, o_count, 8'(v.n));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_color = rgb(9, 9, 9);
            in_addr  = '0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, o_valid, 1'b1);
            chk({tag, "_hold_ready"}, o_ready, 1'b0);
            chk({tag, "_hold_color"}, o_color, v.q);
            chk({tag, "_hold_addr"}, o_addr, v.addr);
            chk({tag, "_hold_count"}, o_count, 8'(v.n));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, o_valid, 1'b0);
        chk({tag, "_ready_back"}, o_ready, 1'b1);
    endtask

    initial begin
        tbl[0] = '{2, '0, 19'h00ABC, 1'b0, 1'b1, rgb16(31, 61, 92), 8'd2, rgb(15, 30, 46)};
        tbl[0].c[0] = rgb(10, 20, 30);
        tbl[0].c[1] = rgb(20, 40, 61);
        tbl[1] = '{1, '0, 19'h01234, 1'b0, 1'b0, '0, 8'd0, rgb(200, 100, 50)};
        tbl[1].c[0] = rgb(200, 100, 50);
        tbl[2] = '{3, '0, 19'h7FFFF, 1'b0, 1'b1, rgb16(10, 10, 10), 8'd3, rgb(3, 3, 3)};
        tbl[2].c[0] = rgb(3, 3, 3);
        tbl[2].c[1] = rgb(3, 3, 3);
        tbl[2].c[2] = rgb(3, 3, 3);
        tbl[3] = '{3, '0, 19'h40000, 1'b0, 1'b1, rgb16(257, 258, 259), 8'd3, rgb(85, 86, 86)};
        tbl[3].c[0] = rgb(0, 0, 0);
        tbl[3].c[1] = rgb(255, 255, 255);
        tbl[3].c[2] = rgb(1, 2, 3);
        tbl[4] = '{2, '0, 19'h00001, 1'b1, 1'b1, rgb16(3, 3, 3), 8'd2, rgb(1, 1, 1)};
        tbl[4].c[0] = rgb(1, 1, 1);
        tbl[4].c[1] = rgb(2, 2, 2);
        tbl[5] = '{2, '0, 19'h12345, 1'b1, 1'b1, rgb16(11, 13, 15), 8'd2, rgb(5, 6, 7)};
        tbl[5].c[0] = rgb(5, 6, 7);
        tbl[5].c[1] = rgb(6, 7, 8);
        tbl[6] = '{2, '0, 19'h00777, 1'b0, 1'b1, rgb16(11, 11, 11), 8'd2, rgb(5, 5, 5)};
        tbl[6].c[0] = rgb(4, 4, 4);
        tbl[6].c[1] = rgb(6, 6, 6);

        sel       = 1'b0;
        div_en    = 1'b1;
        stray     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_color  = '0;
        in_addr   = '0;
        out_ready = 1'b0;
        resetn    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", o_ready, 1'b1);
        chk("rst_out_valid", o_valid, 1'b0);
        chk("rst_strobe", o_strobe, 1'b0);
        chk("rst_div_a", o_a, '0);
        chk("rst_div_b", o_b, 8'd0);
        chk("rst_out_color", o_color, '0);
        resetn = 1'b1;
        @(negedge clk);

        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        chk("idle_last_valid", o_valid, 1'b0);
        chk("idle_last_strobe", o_strobe, 1'b0);
        chk("idle_last_ready", o_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_pixel($sformatf("vec%0d", i), tbl[i], 0);
        end

        run_pixel("hold", tbl[0], 10);
        run_pixel("after_hold", tbl[6], 0);

        sel = 1'b0;
        for (int s = 0; s < 255; s++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_color = rgb(255, 255, 255);
            in_addr  = (s == 0) ? 19'h2A2A2 : 19'h00000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("max_in_ready", o_ready, 1'b0);
        chk("max_strobe", o_strobe, 1'b1);
        chk("max_div_a", o_a, rgb16(65152, 65152, 65152));
        chk("max_div_b", o_b, 8'd255);
        begin
            int cyc;
            cyc = 0;
            while (!o_valid && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("max_out_valid", o_valid, 1'b1);
        chk("max_out_color", o_color, rgb(255, 255, 255));
        chk("max_out_count", o_count, 8'd255);
        chk("max_out_addr", o_addr, 19'h2A2A2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("max_ready_back", o_ready, 1'b1);

        div_en = 1'b0;
        in_valid = 1'b1;
        in_addr  = 19'h55555;
        in_color = rgb(100, 100, 100);
        @(negedge clk);
        in_color = rgb(50, 50, 50);
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_in_ready", o_ready, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_in_ready", o_ready, 1'b1);
        chk("mid_rst_out_valid", o_valid, 1'b0);
        chk("mid_rst_strobe", o_strobe, 1'b0);
        chk("mid_rst_div_a", o_a, '0);
        chk("mid_rst_div_b", o_b, 8'd0);
        chk("mid_rst_out_color", o_color, '0);
        chk("mid_rst_out_addr", o_addr, '0);
        chk("mid_rst_out_count", o_count, 8'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_out_valid", o_valid, 1'b0);
        chk("stray_in_ready", o_ready, 1'b1);
        chk("stray_out_color", o_color, '0);
        repeat (2) @(negedge clk);
        chk("stray_later_valid", o_valid, 1'b0);
        div_en = 1'b1;
        run_pixel("post_rst", tbl[2], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb8_sample_accum.md
Name: rgb8_sample_accum

Overview:
- Upstream feeder for the RGB8 per-channel divider (RGB8_Div_V2/V3 family).
- Accumulates a stream of RGB8 samples for one pixel: multi-sample / progressive averaging in the ray tracer's shading path.
- On the pixel's last sample, issues one divide request (channel sums, sample count) and waits for the quotient.
- Emits the averaged RGB8 pixel with its address over a valid/ready handshake.

Parameters:
- MAX_SAMPLES, 255: samples per pixel before forced completion; range 1..255.
- ADDR_W, 19: pixel address width (640x480 fits).
- ROUND, 1: 1 = add count>>1 to each sum before the divide (round-to-nearest); 0 = truncate.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_color  in  RGB8  sample colour.
- in_last  in  1  final sample of the pixel.
- in_addr  in  ADDR_W  pixel address; sampled with the first sample of a pixel.
- div_strobe  out  1  one-cycle divide request.
- div_a  out  3x16  per-channel dividend.
- div_b  out  8  divisor = sample count.
- div_valid  in  1  divider result valid.
- div_q  in  RGB8  divider quotient.
- out_valid  out  1  averaged pixel available.
- out_ready  in  1  consumer accepts the pixel.
- out_color  out  RGB8  averaged colour.
- out_addr  out  ADDR_W  pixel address.
- out_count  out  8  samples averaged.

Behaviour:
- Reset (async, resetn=0): state ACCUM; sums=0; count=0; in_ready=1; div_strobe=0; out_valid=0; div_a=0; div_b=0; out_color=0; out_addr=0; out_count=0.
- States: ACCUM, DIV_REQ, DIV_WAIT, OUTPUT.
- ACCUM:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept: each 16-bit channel sum += in_color channel; count += 1.
  - On an accept with count==0, latch in_addr.
  - Completion = accepted sample with in_last=1, or accepted sample that brings count to MAX_SAMPLES (forced).
- Completion, count_next==1 (bypass):
  - Go straight to OUTPUT; out_color = that sample.
  - No div_strobe.
  - out_valid rises the cycle after accept.
- Completion, count_next>1:
  - Register div_a[c] = sum_next[c] + (ROUND ? count_next>>1 : 0); div_b = count_next.
  - Go to DIV_REQ.
  - Width check: 255*255+127 = 65152 < 2^16, so no overflow; the quotient is always <= 255.
- DIV_REQ:
  - div_strobe=1 for exactly one cycle, then DIV_WAIT.
  - div_a and div_b stay stable from DIV_REQ until leaving DIV_WAIT.
- DIV_WAIT:
  - div_strobe=0.
  - On div_valid: capture div_q into out_color, go to OUTPUT.
  - Wait is unbounded; the divider guarantees completion since b>=2.
- OUTPUT:
  - out_valid=1; out_color, out_addr, out_count stable while out_valid & !out_ready.
  - On out_ready: clear sums and count, go to ACCUM; out_valid falls the next cycle.
  - in_ready=1 again the next cycle, so no same-cycle pass-through.
- in_ready=0 in DIV_REQ, DIV_WAIT and OUTPUT.
- div_valid outside DIV_WAIT is ignored.
- in_last with no accepted sample (in_valid=0) has no effect.
- A zero-count pixel cannot occur: completion always coincides with an accepted sample.
- Reset mid-operation (any state): all outputs return to reset values immediately; partial sums are discarded; any outstanding divider result is ignored.
- Throughput:
  - Bypass pixel: N + 2 cycles minimum including the handshake.
  - Divided pixel: adds 1 + divider latency.

Decomposition:
- Shared package, alongside RGB8 in Fixed.sv:
  - RGB16 sum typedef: 3 x 16-bit channels.
  - AccumState enum: ACCUM, DIV_REQ, DIV_WAIT, OUTPUT.
  - Default MAX_SAMPLES constant.
- No sub-module: the three channel accumulators are a generate loop.
- The divider is instantiated by the parent, not inside this block. The top-level bench wires this block to RGB8_Div_V2.

Test Plan:
- Two samples (10,20,30), (20,40,61), last on 2nd, ROUND=1 -> div_a=(31,61,92), div_b=2, one div_strobe pulse; out_color=(15,30,46), out_count=2, out_addr = address from 1st sample.
- Single sample (200,100,50) with last, addr 0x1234 -> no div_strobe; out_valid the cycle after accept with (200,100,50), count 1, addr 0x1234.
- 255 samples of (255,255,255), never last -> forced completion at count 255, div_a=(65152,65152,65152), div_b=255; out_color=(255,255,255); in_ready=0 from the cycle after the 255th accept.
- Hold out_ready=0 for 10 cycles in OUTPUT -> out_* stable, in_ready=0, in_valid ignored; after out_ready=1, next pixel sums start from 0.
- Assert resetn=0 during DIV_WAIT, then pulse div_valid after release -> all outputs at reset values, stray div_valid ignored, next pixel (3,3,3)x3 gives (3,3,3).
- ROUND=0, samples (1,1,1), (2,2,2) -> div_a=(3,3,3), div_b=2, out_color=(1,1,1).
